// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Holds the transmitter state encoding and oversampling ratio.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Registered occupancy count; writes while full are dropped.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // pointers and occupancy; simultaneous push/pop keeps count
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO plus 8N1 serialiser on 16x ticks.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1 frames).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int TW = (STOP_TICKS > OVERSAMPLE)
                    ? $clog2(STOP_TICKS)
                    : $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_tx_state_t       state;
  uart_tx_state_t       state_n;
  logic [TW-1:0]        tick;
  logic [TW-1:0]        tick_n;
  logic [BW-1:0]        bitc;
  logic [BW-1:0]        bitc_n;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_n;
  logic                 tx_n;
  logic                 done;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 empty;
`ifdef UART_TX_PARITY_EN
  logic                 par;
  logic                 par_n;
`endif

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full)
  );

  assign tx_busy      = (state != ST_IDLE);
  assign tx_done_tick = done & reset;

  // frame state, counters and line register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      tick  <= '0;
      bitc  <= '0;
      shift <= '0;
      tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      tick  <= tick_n;
      bitc  <= bitc_n;
      shift <= shift_n;
      tx    <= tx_n;
`ifdef UART_TX_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  // next-state, counter and FIFO pop logic
  always_comb begin
    state_n = state;
    tick_n  = tick;
    bitc_n  = bitc;
    shift_n = shift;
    rd_en   = 1'b0;
    done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          rd_en   = 1'b1;
          shift_n = rd_data;
          tick_n  = '0;
          bitc_n  = '0;
          state_n = ST_START;
`ifdef UART_TX_PARITY_EN
          par_n   = ^rd_data;
`endif
        end
      end
      ST_START: begin
        if (sample_tick) begin
          if (tick == TICK_LAST) begin
            tick_n  = '0;
            state_n = ST_DATA;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (sample_tick) begin
          if (tick == TICK_LAST) begin
            tick_n  = '0;
            shift_n = shift >> 1;
            if (bitc == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              bitc_n = bitc + 1'b1;
            end
          end else begin
            tick_n = tick + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (sample_tick) begin
          if (tick == TICK_LAST) begin
            tick_n  = '0;
            state_n = ST_STOP;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (sample_tick) begin
          if (tick == STOP_LAST) begin
            done    = 1'b1;
            tick_n  = '0;
            state_n = ST_IDLE;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        tick_n  = '0;
        bitc_n  = '0;
      end
    endcase
  end

  // line level derived from the upcoming state
  always_comb begin
    tx_n = 1'b1;
    unique case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_n = par_n;
`endif
      default:  tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered.
// Model receiver decodes tx into a queue checked against a scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NSLOT = 10 + PB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sample_tick = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  logic          tx;
  logic          tx_busy;
  logic          tx_done_tick;

  int n_checks = 0;
  int n_fail = 0;
  bit tick_en = 1'b1;
  int tcnt = 0;
  int done_cnt = 0;
  int ferr = 0;

  logic [DW-1:0] expq[$];
  logic [DW-1:0] rxq[$];
  logic          parq[$];

  uart_tx_buffered #(
    .DATA_BITS  (DW),
    .FIFO_DEPTH (4),
    .STOP_TICKS (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  // one tick every 4 clocks while enabled
  always @(posedge clk) begin
    tcnt <= (tcnt == 3) ? 0 : tcnt + 1;
    sample_tick <= tick_en && (tcnt == 2);
  end

  // model receiver: mid-bit sampling on the 16x ticks
  int rstate = 0;
  int rcnt = 0;
  int ridx;
  logic [DW-1:0] rsh;
  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_cnt++;
    if (!reset) begin
      rstate = 0;
      rxq.delete();
      parq.delete();
    end else if (sample_tick) begin
      if (rstate == 0) begin
        if (tx === 1'b0) begin
          rstate = 1;
          rcnt = 1;
        end
      end else begin
        rcnt++;
        if (rcnt == 8 && tx !== 1'b0) begin
          rstate = 0;
        end else if (rcnt > 8 && (rcnt - 8) % 16 == 0) begin
          ridx = (rcnt - 8) / 16;
          if (ridx <= DW) begin
            rsh = {tx, rsh[DW-1:1]};
          end else if (PB == 1 && ridx == DW + 1) begin
            parq.push_back(tx);
          end else begin
            if (tx === 1'b1) rxq.push_back(rsh);
            else ferr++;
            rstate = 0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b0 && sample_tick === 1'b0) ok = 1'b1;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL idle_wait: busy=%b required 0", tx_busy);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(negedge clk);
      if (sample_tick) c++;
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (tx === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (rxq.size() > 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tx: got %b required 1", tx);
    end
    n_checks++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b required 0", tx_busy);
    end
    n_checks++;
    if (tx_done_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b required 0", tx_done_tick);
    end
    n_checks++;
    if (full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_full: got %b required 0", full);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic          samp [NSLOT*16];
    logic          slot_v [NSLOT];
    logic [DW-1:0] b;
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    int            n;
    int            d0;
    int            match;
    bit            ok;
    b = 8'hA5;
    slot_v[0] = 1'b0;
    for (int j = 0; j < DW; j++) slot_v[j+1] = b[j];
    if (PB == 1) slot_v[DW+1] = ^b;
    slot_v[NSLOT-1] = 1'b1;
    wait_idle();
    d0 = done_cnt;
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
    expq.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    for (int g = 0; g < 5000 && n < NSLOT*16; g++) begin
      if (g > 0) @(negedge clk);
      if (sample_tick && (n > 0 || tx === 1'b0)) begin
        samp[n] = tx;
        n++;
      end
    end
    n_checks++;
    if (n < NSLOT*16) begin
      n_fail++;
      $display("FAIL single_ticks: got %0d samples required %0d", n, NSLOT*16);
    end
    n_checks++;
    if (tx_done_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done_at_last_tick: got %b required 1", tx_done_tick);
    end
    for (int s = 0; s < NSLOT; s++) begin
      match = 0;
      for (int k = 0; k < 16; k++)
        if (samp[s*16+k] === slot_v[s]) match++;
      n_checks++;
      if (match != 16) begin
        n_fail++;
        $display("FAIL single_slot%0d: %0d of 16 ticks at %b, required 16",
                 s, match, slot_v[s]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_after_done: got %b required 0", tx_busy);
    end
    wait_rx(ok);
    want = expq.pop_front();
    got = ok ? rxq.pop_front() : 'x;
    n_checks++;
    if (!ok || got !== want) begin
      n_fail++;
      $display("FAIL single_rx: got %h required %h", got, want);
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL single_done_count: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_loopback();
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    int            d0;
    int            f0;
    bit            ok;
    wait_idle();
    d0 = done_cnt;
    f0 = ferr;
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h3C;
    expq.push_back(8'h3C);
    @(negedge clk);
    wr_data = 8'hFF;
    expq.push_back(8'hFF);
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_rx(ok);
      want = expq.pop_front();
      got = ok ? rxq.pop_front() : 'x;
      n_checks++;
      if (!ok || got !== want) begin
        n_fail++;
        $display("FAIL loopback_rx%0d: got %h required %h", k, got, want);
      end
    end
    wait_idle();
    n_checks++;
    if (done_cnt - d0 != 2) begin
      n_fail++;
      $display("FAIL loopback_done_count: got %0d required 2", done_cnt - d0);
    end
    n_checks++;
    if (ferr != f0) begin
      n_fail++;
      $display("FAIL loopback_framing: got %0d errors required 0", ferr - f0);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    logic          exp_full;
    bit            ok;
    wait_idle();
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      @(negedge clk);
      if (i >= 4) begin
        exp_full = (i >= 5);
        n_checks++;
        if (full !== exp_full) begin
          n_fail++;
          $display("FAIL overflow_full_w%0d: got %b required %b", i, full, exp_full);
        end
      end
    end
    wr_en = 1'b0;
    for (int i = 1; i <= 5; i++) expq.push_back(8'(i));
    for (int k = 0; k < 5; k++) begin
      wait_rx(ok);
      want = expq.pop_front();
      got = ok ? rxq.pop_front() : 'x;
      n_checks++;
      if (!ok || got !== want) begin
        n_fail++;
        $display("FAIL overflow_rx%0d: got %h required %h", k, got, want);
      end
    end
    wait_idle();
    repeat (800) @(negedge clk);
    n_checks++;
    if (rxq.size() != 0 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_dropped: %0d extra bytes busy=%b required 0 and 0",
               rxq.size(), tx_busy);
    end
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    int            bad;
    bit            ok;
    wait_idle();
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h11;
    @(negedge clk);
    wr_data = 8'h22;
    @(negedge clk);
    wr_data = 8'h33;
    @(negedge clk);
    wr_en = 1'b0;
    wait_start(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstmid_start: tx=%b required 0", tx);
    end
    wait_ticks(56);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_tx: got %b required 1", tx);
    end
    n_checks++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_busy: got %b required 0", tx_busy);
    end
    n_checks++;
    if (full !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_full: got %b required 0", full);
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || rxq.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: %0d active cycles %0d bytes required 0 and 0",
               bad, rxq.size());
    end
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h5A;
    expq.push_back(8'h5A);
    @(negedge clk);
    wr_en = 1'b0;
    wait_rx(ok);
    want = expq.pop_front();
    got = ok ? rxq.pop_front() : 'x;
    n_checks++;
    if (!ok || got !== want) begin
      n_fail++;
      $display("FAIL rstmid_after_rx: got %h required %h", got, want);
    end
  endtask

  task automatic test_tick_stall();
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    logic          tx0;
    int            bad;
    bit            ok;
    wait_idle();
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h96;
    expq.push_back(8'h96);
    @(negedge clk);
    wr_en = 1'b0;
    wait_start(ok);
    wait_ticks(40);
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    tx0 = tx;
    n_checks++;
    if (!ok || tx0 !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_bit1: got %b required 1", tx0);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== tx0 || tx_busy !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d changed cycles required 0", bad);
    end
    tick_en = 1'b1;
    wait_rx(ok);
    want = expq.pop_front();
    got = ok ? rxq.pop_front() : 'x;
    n_checks++;
    if (!ok || got !== want) begin
      n_fail++;
      $display("FAIL stall_rx: got %h required %h", got, want);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [DW-1:0] vals [2];
    logic          pwant [2];
    logic [DW-1:0] got;
    logic [DW-1:0] want;
    logic          pgot;
    bit            ok;
    vals[0] = 8'h07;
    pwant[0] = 1'b1;
    vals[1] = 8'h03;
    pwant[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_idle();
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = vals[k];
      expq.push_back(vals[k]);
      @(negedge clk);
      wr_en = 1'b0;
      wait_rx(ok);
      want = expq.pop_front();
      got = ok ? rxq.pop_front() : 'x;
      pgot = (ok && parq.size() > 0) ? parq.pop_front() : 1'bx;
      n_checks++;
      if (!ok || got !== want) begin
        n_fail++;
        $display("FAIL parity_rx%0d: got %h required %h", k, got, want);
      end
      n_checks++;
      if (pgot !== pwant[k]) begin
        n_fail++;
        $display("FAIL parity_bit%0d: got %b required %b", k, pgot, pwant[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_loopback();
    test_overflow();
    test_reset_midframe();
    test_tick_stall();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
